fsm_out_capture: RTL

FSM_OUT_CAPTURE -- requirements
Module: fsm_out_capture

---
 rtl/fsm_cap_pkg.sv | 31 +++
 rtl/fsm_cap_fifo.sv | 63 ++++++
 rtl/fsm_out_capture.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fsm_cap_pkg.sv
// Shared types and constants for the FSM output capture block.
// State encoding, stamp/signature widths and the MISR polynomial live here.
package fsm_cap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int STAMP_W = 8;
    localparam int SIG_W   = 16;

    // x^16 + x^12 + x^3 + x + 1 (x^16 term implicit)
    localparam logic [SIG_W-1:0] MISR_POLY = 16'h100B;
    localparam logic [SIG_W-1:0] MISR_SEED = 16'hFFFF;

    // One Galois MISR step: shift, fold the carry, absorb the data word.
    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0] sig,
        input logic [SIG_W-1:0] din
    );
        logic [SIG_W-1:0] sh;
        sh = {sig[SIG_W-2:0], 1'b0};
        if (sig[SIG_W-1]) begin
            sh = sh ^ MISR_POLY;
        end
        return sh ^ din;
    endfunction

endpackage

// File: rtl/fsm_cap_fifo.sv
// Synchronous FIFO holding captured {stamp, y} entries.
// Head word reads as zero while empty; a push is visible the next cycle.
module fsm_cap_fifo #(
    parameter int W     = 21,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are don't-care until counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (!do_push && do_pop) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/fsm_out_capture.sv
// Captures changes of an upstream FSM output vector with a time stamp.
// Optional MISR signature is built when FSM_CAP_MISR_EN is defined.
module fsm_out_capture
    import fsm_cap_pkg::*;
#(
    parameter int YW    = 13,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [YW-1:0]         y_in,
    input  logic                  y_valid,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [YW+STAMP_W-1:0] out_data,
    output logic                  busy,
    output logic                  overflow,
    output logic [SIG_W-1:0]      signature
);

    localparam logic [STAMP_W-1:0] STAMP_ONE = STAMP_W'(1);

    state_t             state;
    logic [STAMP_W-1:0] stamp;
    logic [YW-1:0]      last_y;
    logic               first;
    logic               sample;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               begin_run;

    assign sample    = (state == RUN) && y_valid;
    assign push      = sample && (first || (y_in != last_y));
    assign pop       = !empty && out_ready;
    assign out_valid = !empty;
    assign begin_run = (state == IDLE) && start && !stop;

    fsm_cap_fifo #(
        .W     (YW + STAMP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({stamp, y_in}),
        .rdata (out_data),
        .full  (full),
        .empty (empty)
    );

    // Control FSM with stamp, change tracking and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            stamp    <= '0;
            last_y   <= '0;
            first    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (sample) begin
                stamp  <= stamp + STAMP_ONE;
                last_y <= y_in;
                first  <= 1'b0;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (begin_run) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        stamp    <= '0;
                        first    <= 1'b1;
                        overflow <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        if (!empty || push) begin
                            state <= FLUSH;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (empty) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FSM_CAP_MISR_EN
    logic [SIG_W-1:0] sig_q;

    // MISR compacts every RUN sample; reseeded at each capture start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else if (begin_run) begin
            sig_q <= MISR_SEED;
        end else if (sample) begin
            sig_q <= misr_step(sig_q, SIG_W'(y_in));
        end
    end

    assign signature = sig_q;
`else
    assign signature = '0;
`endif

endmodule
